// File: rtl/riscv_pkg.sv
// Shared decode definitions: immediate format codes, base opcodes and the
// XLEN legality check used by the decode stage and its immediate generator.
package riscv_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_t;

  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_OPIMM   = 7'b0010011;
  localparam logic [6:0] OP_MISCMEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_OP      = 7'b0110011;
  localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OP_OP32    = 7'b0111011;

  // Only 32- and 64-bit datapaths are meaningful.
  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator.
//   instr   : raw 32-bit instruction word
//   imm     : immediate, sign-extended to XLEN (0 for R-type and illegal)
//   fmt     : immediate format code
//   illegal : opcode not recognised for this XLEN
module imm_gen
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            illegal
);

  // The *W opcodes exist only on a legal 64-bit datapath.
  localparam bit RV64 = xlen_legal(XLEN) && (XLEN == 64);

  logic [31:0] imm32;

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b1;
    case (instr[6:0])
      OP_LUI, OP_AUIPC: begin
        fmt     = FMT_U;
        illegal = 1'b0;
        imm32   = {instr[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt     = FMT_J;
        illegal = 1'b0;
        imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                   instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_OPIMM, OP_MISCMEM, OP_SYSTEM: begin
        fmt     = FMT_I;
        illegal = 1'b0;
        imm32   = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        fmt     = FMT_S;
        illegal = 1'b0;
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        fmt     = FMT_B;
        illegal = 1'b0;
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                   instr[11:8], 1'b0};
      end
      OP_OP: begin
        fmt     = FMT_R;
        illegal = 1'b0;
      end
      OP_OPIMM32: begin
        if (RV64) begin
          fmt     = FMT_I;
          illegal = 1'b0;
          imm32   = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OP_OP32: begin
        if (RV64) begin
          fmt     = FMT_R;
          illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Every immediate is built as a signed 32-bit value, then widened.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// Decode pipeline stage: decodes the immediate on the input side and holds
// results in a main output register backed by one skid register.
//   clk, rst_n          : clock, async active-low reset
//   flush               : synchronous flush, empties the stage
//   in_valid/in_ready   : upstream handshake, in_instr payload
//   out_valid/out_ready : downstream handshake
//   out_instr/imm/fmt/illegal : decoded result of the head entry
//   illegal_cnt         : saturating count of accepted illegal instructions
module imm_decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    fmt_t            fmt;
    logic            illegal;
  } entry_t;

  state_t          state, state_nx;
  entry_t          main_q, skid_q, dec;
  logic [XLEN-1:0] dec_imm;
  fmt_t            dec_fmt;
  logic            dec_illegal;
  logic            in_fire, out_fire;
  logic            load_main, load_skid, main_from_skid;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  always_comb begin
    dec.instr   = in_instr;
    dec.imm     = dec_imm;
    dec.fmt     = dec_fmt;
    dec.illegal = dec_illegal;
  end

  // Flush blocks acceptance; an output transfer in the same cycle still counts.
  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nx  = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            state_nx  = TWO;
            load_skid = 1'b1;
          end else if (!in_fire && out_fire) begin
            state_nx = EMPTY;
          end else if (in_fire && out_fire) begin
            load_main = 1'b1;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_nx       = ONE;
            main_from_skid = 1'b1;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready    = (state != TWO);
    out_valid   = (state != EMPTY);
    out_instr   = main_q.instr;
    out_imm     = main_q.imm;
    out_fmt     = main_q.fmt;
    out_illegal = main_q.illegal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '{instr: '0, imm: '0, fmt: FMT_NONE, illegal: 1'b0};
      skid_q <= '{instr: '0, imm: '0, fmt: FMT_NONE, illegal: 1'b0};
    end else begin
      if (load_main)           main_q <= dec;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (in_fire && dec_illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: a 32-bit/16-bit-counter instance and a
// 64-bit/2-bit-counter instance share the same stimulus and are compared
// against a queue-based model of the stage and an arithmetic immediate model.
module tb_imm_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;

  logic        rdy32, vld32, ill32;
  logic [31:0] oi32, imm32;
  logic [2:0]  fmt32;
  logic [15:0] cnt32;

  logic        rdy64, vld64, ill64;
  logic [31:0] oi64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [1:0]  cnt64;

  imm_decode_stage #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
    .out_valid(vld32), .out_ready(out_ready), .out_instr(oi32),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32),
    .illegal_cnt(cnt32)
  );

  imm_decode_stage #(.XLEN(64), .CNT_W(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .out_valid(vld64), .out_ready(out_ready), .out_instr(oi64),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64),
    .illegal_cnt(cnt64)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q[$];
  int          exp_cnt32 = 0;
  int          exp_cnt64 = 0;

  logic        g_valid32, g_ready32, g_ill32, g_valid64, g_ill64;
  logic [31:0] g_instr32, g_imm32;
  logic [63:0] g_imm64;
  logic [2:0]  g_fmt32, g_fmt64;
  logic [15:0] g_cnt32;
  logic [1:0]  g_cnt64;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Immediate value computed as a signed number from its bit fields' weights.
  function automatic void ref_decode(input logic [31:0] w, input bit is64,
                                     output longint imm, output fmt_t fmt, output bit ill);
    longint neg;
    imm = 0;
    fmt = FMT_NONE;
    ill = 1'b1;
    case (w[6:0])
      7'h37, 7'h17: begin
        fmt = FMT_U; ill = 1'b0;
        imm = longint'(int'(w & 32'hFFFF_F000));
      end
      7'h6F: begin
        fmt = FMT_J; ill = 1'b0;
        neg = w[31] ? -(longint'(1) << 20) : 0;
        imm = neg + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
              + longint'(w[30:21]) * 2;
      end
      7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: begin
        fmt = FMT_I; ill = 1'b0;
        neg = w[31] ? -longint'(2048) : 0;
        imm = neg + longint'(w[30:20]);
      end
      7'h23: begin
        fmt = FMT_S; ill = 1'b0;
        neg = w[31] ? -longint'(2048) : 0;
        imm = neg + longint'(w[30:25]) * 32 + longint'(w[11:7]);
      end
      7'h63: begin
        fmt = FMT_B; ill = 1'b0;
        neg = w[31] ? -longint'(4096) : 0;
        imm = neg + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
              + longint'(w[11:8]) * 2;
      end
      7'h33: begin
        fmt = FMT_R; ill = 1'b0;
      end
      7'h1B: begin
        if (is64) begin
          fmt = FMT_I; ill = 1'b0;
          neg = w[31] ? -longint'(2048) : 0;
          imm = neg + longint'(w[30:20]);
        end
      end
      7'h3B: begin
        if (is64) begin
          fmt = FMT_R; ill = 1'b0;
        end
      end
      default: ;
    endcase
  endfunction

  // One clock cycle: check both instances against the model, drive the
  // inputs for the coming edge, then advance the model across that edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
    longint      e_imm;
    fmt_t        e_fmt;
    bit          e_ill, fi, fo, i32, i64;
    logic [63:0] e64;
    @(negedge clk);
    check("in_ready32", 64'(rdy32), 64'(q.size() < 2));
    check("in_ready64", 64'(rdy64), 64'(q.size() < 2));
    check("out_valid32", 64'(vld32), 64'(q.size() > 0));
    check("out_valid64", 64'(vld64), 64'(q.size() > 0));
    if (q.size() > 0) begin
      ref_decode(q[0], 1'b0, e_imm, e_fmt, e_ill);
      e64 = e_imm;
      check("instr32", 64'(oi32), 64'(q[0]));
      check("imm32", 64'(imm32), 64'(e64[31:0]));
      check("fmt32", 64'(fmt32), 64'(e_fmt));
      check("illegal32", 64'(ill32), 64'(e_ill));
      ref_decode(q[0], 1'b1, e_imm, e_fmt, e_ill);
      e64 = e_imm;
      check("instr64", 64'(oi64), 64'(q[0]));
      check("imm64", imm64, e64);
      check("fmt64", 64'(fmt64), 64'(e_fmt));
      check("illegal64", 64'(ill64), 64'(e_ill));
    end
    check("cnt32", 64'(cnt32), 64'(exp_cnt32));
    check("cnt64", 64'(cnt64), 64'(exp_cnt64));
    g_valid32 = vld32; g_ready32 = rdy32; g_ill32 = ill32; g_instr32 = oi32;
    g_imm32 = imm32; g_fmt32 = fmt32; g_cnt32 = cnt32;
    g_valid64 = vld64; g_ill64 = ill64; g_imm64 = imm64; g_fmt64 = fmt64;
    g_cnt64 = cnt64;
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    fi = v && (q.size() < 2) && !fl;
    fo = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fo) void'(q.pop_front());
    if (fl) begin
      q.delete();
    end else if (fi) begin
      q.push_back(ins);
      ref_decode(ins, 1'b0, e_imm, e_fmt, i32);
      ref_decode(ins, 1'b1, e_imm, e_fmt, i64);
      if (i32 && exp_cnt32 < 65535) exp_cnt32++;
      if (i64 && exp_cnt64 < 3)     exp_cnt64++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_valid32", 64'(vld32), 64'd0);
    check("rst_valid64", 64'(vld64), 64'd0);
    check("rst_cnt32", 64'(cnt32), 64'd0);
    check("rst_cnt64", 64'(cnt64), 64'd0);
    check("rst_imm32", 64'(imm32), 64'd0);
    check("rst_imm64", imm64, 64'd0);
    check("rst_instr32", 64'(oi32), 64'd0);
    check("rst_fmt32", 64'(fmt32), 64'(FMT_NONE));
    check("rst_fmt64", 64'(fmt64), 64'(FMT_NONE));
    check("rst_illegal32", 64'(ill32), 64'd0);
    q.delete();
    exp_cnt32 = 0;
    exp_cnt64 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready32", 64'(rdy32), 64'd1);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F,
                              7'h73, 7'h23, 7'h63, 7'h33, 7'h1B, 7'h3B};
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31:7], ops[$urandom_range(0, 12)]};
  endfunction

  initial begin
    do_reset();

    // single transfer: addi -1
    step(1'b1, 32'hFFF0_0093, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("addi_valid", 64'(g_valid32), 64'd1);
    check("addi_fmt", 64'(g_fmt32), 64'(FMT_I));
    check("addi_imm32", 64'(g_imm32), 64'hFFFF_FFFF);
    check("addi_imm64", g_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_illegal", 64'(g_ill32), 64'd0);

    // back-pressure with three instructions
    step(1'b1, 32'h0010_0093, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0093, 1'b0, 1'b0);
    check("bp_ready_after1", 64'(g_ready32), 64'd1);
    step(1'b1, 32'h0030_0093, 1'b0, 1'b0);
    check("bp_ready_drop", 64'(g_ready32), 64'd0);
    step(1'b1, 32'h0030_0093, 1'b0, 1'b0);
    step(1'b1, 32'h0030_0093, 1'b1, 1'b0);
    check("bp_first", 64'(g_instr32), 64'h0010_0093);
    step(1'b1, 32'h0030_0093, 1'b1, 1'b0);
    check("bp_second", 64'(g_instr32), 64'h0020_0093);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_third", 64'(g_instr32), 64'h0030_0093);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("bp_drained", 64'(g_valid32), 64'd0);

    // B and J decode
    step(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0);
    step(1'b1, 32'h0000_006F, 1'b1, 1'b0);
    check("b_fmt", 64'(g_fmt32), 64'(FMT_B));
    check("b_imm32", 64'(g_imm32), 64'hFFFF_FFFC);
    check("b_imm64", g_imm64, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 32'h8000_006F, 1'b1, 1'b0);
    check("j_fmt", 64'(g_fmt32), 64'(FMT_J));
    check("j_imm32", 64'(g_imm32), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("jneg_imm32", 64'(g_imm32), 64'hFFF0_0000);
    check("jneg_imm64", g_imm64, 64'hFFFF_FFFF_FFF0_0000);

    // illegal instructions and counter saturation
    do_reset();
    step(1'b1, 32'h0000_0000, 1'b1, 1'b0);
    step(1'b1, 32'h0000_001B, 1'b1, 1'b0);
    check("ill0_illegal", 64'(g_ill32), 64'd1);
    check("ill0_fmt", 64'(g_fmt32), 64'(FMT_NONE));
    check("ill0_imm", 64'(g_imm32), 64'd0);
    step(1'b1, 32'h0000_0000, 1'b1, 1'b0);
    check("addiw32_illegal", 64'(g_ill32), 64'd1);
    check("addiw32_fmt", 64'(g_fmt32), 64'(FMT_NONE));
    check("addiw64_fmt", 64'(g_fmt64), 64'(FMT_I));
    check("addiw64_illegal", 64'(g_ill64), 64'd0);
    check("ill_cnt32_two", 64'(g_cnt32), 64'd2);
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 32'h0000_0000, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("ill_cnt32_six", 64'(g_cnt32), 64'd6);
    check("ill_cnt64_sat", 64'(g_cnt64), 64'd3);

    // flush in TWO with in_valid, and flush in ONE suppressing capture
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0033, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0063, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("flush2_valid", 64'(g_valid32), 64'd0);
    check("flush2_ready", 64'(g_ready32), 64'd1);
    step(1'b1, 32'h0000_0013, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0033, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("flush1_valid", 64'(g_valid32), 64'd0);

    // reset while in TWO with a non-zero counter
    step(1'b1, 32'h0000_0000, 1'b0, 1'b0);
    step(1'b1, 32'h0000_0000, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("two_before_reset", 64'(g_ready32), 64'd0);
    do_reset();

    // randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0);
    end
    for (int unsigned i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath width; legal values 32 or 64.
REQ-002 Parameter CNT_W, default 16, meaning width of the illegal-instruction counter.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 flush  input  1  synchronous pipeline flush.
REQ-006 in_valid  input  1  upstream instruction valid.
REQ-007 in_ready  output  1  stage can accept an instruction.
REQ-008 in_instr  input  32  raw instruction word.
REQ-009 out_valid  output  1  decoded result valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 out_instr  output  32  instruction carried with its decode.
REQ-012 out_imm  output  XLEN  sign- or zero-extended immediate.
REQ-013 out_fmt  output  3  format code: R, I, S, B, U, J, NONE.
REQ-014 out_illegal  output  1  opcode not recognised or instr[1:0] != 2'b11.
REQ-015 illegal_cnt  output  CNT_W  count of illegal instructions accepted.

Function
REQ-016 Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
REQ-017 Latency: an accepted instruction appears on the out_* ports on the next cycle if the output register is free.
REQ-018 Buffering: main output register plus one skid register; states EMPTY, ONE (main only), TWO (main + skid).
REQ-019 in_ready shall be 1 iff the skid register is empty (registered, no combinational path from out_ready).
REQ-020 EMPTY --in--> ONE; ONE --in&!out--> TWO; ONE --out&!in--> EMPTY; ONE --in&out--> ONE; TWO --out--> ONE, with the skid entry moving to main.
REQ-021 Out-order equals in-order; no entry shall be dropped or duplicated.
REQ-022 out_* payload shall hold stable while out_valid & !out_ready.
REQ-023 Decode opcode in_instr[6:0] before registering.
REQ-024 Opcodes 0110111 and 0010111: U; imm = {instr[31:12], 12'b0}, sign-extended to XLEN.
REQ-025 Opcode 1101111: J; imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
REQ-026 Opcodes 1100111, 0000011, 0010011, 0001111, 1110011: I; imm = sext(instr[31:20]).
REQ-027 Opcode 0100011: S; imm = sext({instr[31:25], instr[11:7]}).
REQ-028 Opcode 1100011: B; imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
REQ-029 Opcode 0110011: R; imm = 0.
REQ-030 XLEN == 64 only: opcode 0011011 is I and 0111011 is R; at XLEN == 32 these are illegal.
REQ-031 Any other opcode: fmt = NONE, imm = 0, illegal = 1; no value shall be held from a previous instruction.
REQ-032 illegal_cnt shall increment on acceptance of an illegal instruction and saturate at all-ones.
REQ-033 flush shall clear both registers (state EMPTY) on the next edge and suppress any same-cycle input transfer; illegal_cnt is unaffected.
REQ-034 flush with out_valid & out_ready in the same cycle: the output transfer completes and the flush still empties the stage.

Reset
REQ-035 On rst_n low, immediately: out_valid = 0, in_ready = 1 after release, state EMPTY, illegal_cnt = 0.
REQ-036 On rst_n low, out_imm, out_instr and out_illegal = 0, and out_fmt = NONE.
REQ-037 Reset mid-transfer shall discard all buffered entries.

Structure
REQ-038 Format enum, opcode constants and the XLEN legality check shall live in shared package riscv_pkg.
REQ-039 Combinational decode shall be sub-module imm_gen (instr, XLEN -> imm, fmt, illegal); this stage instantiates it once on the input side.

Verification
REQ-040 Single transfer: in_instr 0xFFF00093 (addi -1) with out_ready = 1 -> next cycle fmt I, imm 0xFFFFFFFF, illegal 0.
REQ-041 Back-pressure: feed 3 instructions with out_ready = 0 -> in_ready drops after 2, the third is held upstream, and release yields all 3 in order.
REQ-042 B/J decode: 0xFE000EE3 -> B, imm -4; 0x0000006F -> J, imm 0; at XLEN = 64, sign bits fill [63:32].
REQ-043 Illegal: 0x00000000 and 0x0000001B at XLEN = 32 -> illegal = 1, imm 0, fmt NONE; illegal_cnt = 2; at CNT_W = 2, 5 illegals -> 3.
REQ-044 Flush in state TWO with in_valid = 1 -> next cycle out_valid 0, in_ready 1, and the input is not captured.
REQ-045 Assert rst_n low while in state TWO -> out_valid 0 immediately and illegal_cnt 0.
